// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the Fetch-stage sequencing controller.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      REDIR = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC load/select, IF/ID capture/squash, ID/EX bubble.
// Define FETCH_CTRL_PERF_EN to add saturating stall/wait/flush counters.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef FETCH_CTRL_PERF_EN
   ,
   parameter int          CNT_W    = 32
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic            br_taken_e,
   input  logic [XLEN-1:0] br_target_e,
   input  logic            ld_stall_d,
   input  logic            imem_ack,
   output logic            imem_req,
   output logic [XLEN-1:0] pc_next,
   output logic            pc_we,
   output logic            ifid_we,
   output logic            ifid_flush,
   output logic            idex_flush
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] wait_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pend_target_q, pend_target_d;

   // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      pend_target_d = pend_target_q;
      imem_req      = 1'b0;
      pc_we         = 1'b0;
      pc_next       = pc_plus4;
      ifid_we       = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;

      unique case (state_q)
         BOOT: begin
            pc_we      = 1'b1;
            pc_next    = RESET_PC[XLEN-1:0];
            ifid_flush = 1'b1;
            state_d    = FETCH;
         end

         FETCH: begin
            imem_req = 1'b1;
            if (br_taken_e) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (imem_ack) begin
                  pc_we   = 1'b1;
                  pc_next = br_target_e;
               end else begin
                  // Wrong-path fetch still in flight: park the target until it lands.
                  pend_target_d = br_target_e;
                  state_d       = REDIR;
               end
            end else if (ld_stall_d) begin
               idex_flush = 1'b1;
            end else if (!imem_ack) begin
               ifid_flush = 1'b1;
            end else begin
               pc_we   = 1'b1;
               ifid_we = 1'b1;
            end
         end

         REDIR: begin
            imem_req   = 1'b1;
            ifid_flush = 1'b1;
            if (br_taken_e) begin
               pend_target_d = br_target_e;
               idex_flush    = 1'b1;
            end
            if (imem_ack) begin
               pc_we   = 1'b1;
               pc_next = br_taken_e ? br_target_e : pend_target_q;
               state_d = FETCH;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= BOOT;
         pend_target_q <= RESET_PC[XLEN-1:0];
      end else begin
         state_q       <= state_d;
         pend_target_q <= pend_target_d;
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   logic stall_inc, wait_inc, flush_inc;

   assign stall_inc = (state_q == FETCH) && ld_stall_d && !br_taken_e;
   assign wait_inc  = imem_req && !imem_ack;
   assign flush_inc = (state_q == FETCH) && br_taken_e;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .clear (1'b0),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wait_inc),
      .clear (1'b0),
      .count (wait_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .clear (1'b0),
      .count (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small PC-register model around it.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_plus4;
   logic        br_taken_e;
   logic [31:0] br_target_e;
   logic        ld_stall_d;
   logic        imem_ack;
   logic        imem_req;
   logic [31:0] pc_next;
   logic        pc_we;
   logic        ifid_we;
   logic        ifid_flush;
   logic        idex_flush;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] stall_cnt, wait_cnt, flush_cnt;
`endif

   logic [31:0] pc;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .pc_plus4    (pc_plus4),
      .br_taken_e  (br_taken_e),
      .br_target_e (br_target_e),
      .ld_stall_d  (ld_stall_d),
      .imem_ack    (imem_ack),
      .imem_req    (imem_req),
      .pc_next     (pc_next),
      .pc_we       (pc_we),
      .ifid_we     (ifid_we),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .wait_cnt    (wait_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   // Fetch datapath model: the PC register the controller drives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc <= 32'h0;
      else if (pc_we) pc <= pc_next;
   end
   assign pc_plus4 = pc + 32'd4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle past the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic br, input logic [31:0] tgt, input logic stall, input logic ack);
      br_taken_e  = br;
      br_target_e = tgt;
      ld_stall_d  = stall;
      imem_ack    = ack;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_pc_we", {31'b0, pc_we}, 32'd1);
      check("rst_pc_next", pc_next, 32'h0);
      check("rst_ifid_flush", {31'b0, ifid_flush}, 32'd1);
      check("rst_idex_flush", {31'b0, idex_flush}, 32'd0);
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      check("boot_pc_next", pc_next, 32'h0);
      check("boot_imem_req", {31'b0, imem_req}, 32'd0);
      cyc();

      // Sequential fetch: 0, 4, 8, 12.
      for (int i = 0; i < 4; i++) begin
         check("seq_pc", pc, 32'(i * 4));
         check("seq_pc_next", pc_next, 32'(i * 4 + 4));
         check("seq_we", {29'b0, imem_req, pc_we, ifid_we}, 32'b111);
         cyc();
      end

      // Load-use stall for two cycles at 0x10.
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1);
         check("stall_pc", pc, 32'h10);
         check("stall_ctl", {29'b0, pc_we, ifid_we, idex_flush}, 32'b001);
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("stall_resume", pc_next, 32'h14);
      check("stall_resume_we", {30'b0, pc_we, idex_flush}, 32'b10);
      cyc();

      // Taken branch with ack at 0x14 -> 0x40.
      drive(1'b1, 32'h40, 1'b0, 1'b1);
      check("br_pc_next", pc_next, 32'h40);
      check("br_ctl", {29'b0, pc_we, ifid_flush, idex_flush}, 32'b111);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("br_landed", pc, 32'h40);
      cyc();

      // Branch to 0x80 while the fetch at 0x44 is outstanding.
      drive(1'b1, 32'h80, 1'b0, 1'b0);
      check("redir_enter", {28'b0, imem_req, pc_we, ifid_flush, idex_flush}, 32'b1011);
      cyc();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0);
         check("redir_wait", {28'b0, imem_req, pc_we, ifid_flush, idex_flush}, 32'b1010);
         check("redir_pc_hold", pc, 32'h44);
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("redir_ack_pc_next", pc_next, 32'h80);
      check("redir_ack_ctl", {29'b0, pc_we, ifid_flush, ifid_we}, 32'b110);
      cyc();
      check("redir_landed", pc, 32'h80);
      check("redir_back_fetch", {30'b0, ifid_we, ifid_flush}, 32'b10);
      cyc();

      // Redirect beats load stall at 0x84.
      drive(1'b1, 32'hC0, 1'b1, 1'b1);
      check("prio_pc_next", pc_next, 32'hC0);
      check("prio_ctl", {29'b0, pc_we, ifid_flush, idex_flush}, 32'b111);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("prio_landed", pc, 32'hC0);

      // Enter REDIR, then reset asynchronously mid-cycle.
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("pre_rst_redir", {31'b0, imem_req}, 32'd1);
`ifdef FETCH_CTRL_PERF_EN
      check("stall_cnt", stall_cnt, 32'd2);
      check("flush_cnt", flush_cnt, 32'd4);
`endif
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_req", {31'b0, imem_req}, 32'd0);
      check("async_rst_pc_next", pc_next, 32'h0);
      check("async_rst_pc_we", {31'b0, pc_we}, 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      check("post_rst_pc", pc, 32'h0);

      // Five un-acked fetch cycles, then reset mid-cycle.
      for (int i = 0; i < 5; i++) begin
         check("wait_req", {30'b0, imem_req, pc_we}, 32'b10);
         cyc();
      end
`ifdef FETCH_CTRL_PERF_EN
      check("wait_cnt", wait_cnt, 32'd5);
      #2;
      rst = 1'b0;
      #1;
      check("wait_cnt_rst", wait_cnt, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the pipeline's Fetch stage. It decides each cycle whether the PC register loads, which next-PC value it loads, and whether the IF/ID register captures, holds or is squashed. It arbitrates between the Execute-stage branch redirect, the Decode load-use stall and a variable-latency instruction-memory handshake. It sits beside the Fetch datapath (PC mux, PC register, instruction memory, IF/ID register) and drives that datapath's enables and select.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h00000000, first fetch address after reset
- CNT_W, 32, width of performance counters (used only with FETCH_CTRL_PERF_EN)

- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous and active-low
- pc_plus4  in  XLEN  current PC + 4 from the Fetch adder
- br_taken_e  in  1  branch/jump resolved taken in Execute
- br_target_e  in  XLEN  redirect target from Execute
- ld_stall_d  in  1  load-use hazard detected in Decode
- imem_ack  in  1  instruction word at current PC valid this cycle
- imem_req  out  1  fetch request at current PC
- pc_next  out  XLEN  value loaded into the PC register when pc_we=1
- pc_we  out  1  PC register load enable
- ifid_we  out  1  IF/ID capture enable; 0 holds
- ifid_flush  out  1  load NOP 32'h00000013 into IF/ID; overrides ifid_we
- idex_flush  out  1  insert bubble into ID/EX
- stall_cnt, wait_cnt, flush_cnt  out  CNT_W each  performance counters (only with FETCH_CTRL_PERF_EN)

## Operation
- Registered state: state ∈ {BOOT, FETCH, REDIR}; pend_target (XLEN). All outputs are combinational from state and inputs (Mealy).
- BOOT (reset state): imem_req=0, pc_we=1, pc_next=RESET_PC, ifid_flush=1, idex_flush=0. Next state is FETCH.
- FETCH: imem_req=1. Priority is redirect > load stall > memory wait.
  - br_taken_e, imem_ack=1: pc_we=1, pc_next=br_target_e, ifid_flush=1, idex_flush=1. Stay in FETCH.
  - br_taken_e, imem_ack=0: pend_target<=br_target_e, pc_we=0, ifid_flush=1, idex_flush=1. Next state is REDIR.
  - ld_stall_d (no redirect): pc_we=0, ifid_we=0, idex_flush=1. A word acked this cycle is discarded and re-fetched from the same PC.
  - imem_ack=0 (no redirect, no stall): pc_we=0, ifid_flush=1 (bubble into Decode).
  - Otherwise (normal advance): pc_we=1, pc_next=pc_plus4, ifid_we=1.
- REDIR: imem_req=1. The outstanding wrong-path fetch must complete before the PC changes.
  - imem_ack=1: pc_we=1, pc_next=pend_target, ifid_flush=1. Next state is FETCH.
  - imem_ack=0: pc_we=0, ifid_flush=1.
  - br_taken_e in REDIR: overwrite pend_target with the new target; idex_flush=1.
  - ld_stall_d in REDIR: ignored.
- Default output values when a case does not assign them: pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=0, pc_next=pc_plus4.

## Timing
- While rst=0: state=BOOT, pend_target=RESET_PC, counters=0. Outputs follow BOOT: imem_req=0, pc_we=1, pc_next=RESET_PC, ifid_flush=1.
- First imem_req=1 occurs in the first cycle after reset deassertion plus one clock edge.
- Redirect penalty with imem_ack=1 is 2 squashed slots: IF/ID and ID/EX. Each cycle without ack in REDIR adds one bubble.
- A load stall holds PC and IF/ID for exactly the cycles ld_stall_d=1, with one ID/EX bubble per cycle.
- If reset is asserted mid-REDIR, pend_target is discarded and the block returns to BOOT immediately (asynchronous).

## Configuration
- FETCH_CTRL_PERF_EN defined: adds the three counters and their ports. Counters saturate at all-ones.
  - stall_cnt counts cycles with ld_stall_d=1 in FETCH and no redirect.
  - wait_cnt counts cycles with imem_req=1 and imem_ack=0.
  - flush_cnt counts cycles with ifid_flush=1 caused by br_taken_e.
- Undefined: counters and ports are absent. Control behaviour is identical in both builds.

## Structure
- fetch_ctrl_pkg holds:
  - the state enum (BOOT, FETCH, REDIR)
  - the NOP constant 32'h00000013
  - the default RESET_PC
- The counters use one sub-module, sat_counter (parameter CNT_W; ports inc and clear), instantiated three times under FETCH_CTRL_PERF_EN.

## Test plan
- Reset release with imem_ack tied 1 and pc_plus4 = pc+4: BOOT cycle gives pc_next=0; then pc_we=1 each cycle and the PC sequence is 0,4,8,12.
- br_taken_e=1 with br_target_e=32'h40 and ack=1: same cycle pc_next=32'h40, ifid_flush=1, idex_flush=1; next fetch is at 0x40.
- ack held 0 for 3 cycles, br_taken_e pulsed to 0x80 in the first of them: state REDIR for 3 cycles; on ack, pc_next=0x80 and ifid_flush=1.
- ld_stall_d=1 for 2 cycles at PC 0x10: pc_we=0, ifid_we=0 and idex_flush=1 for 2 cycles; PC then resumes at 0x14.
- br_taken_e and ld_stall_d both high: redirect wins, pc_we=1, pc_next=target.
- PERF build, 5 wait cycles then reset mid-count: wait_cnt reads 5, then reads 0 asynchronously on rst=0.
